// File: rtl/axi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_arb_pkg
// Description : Shared types and constants for the AXI-Lite request arbiter:
//               FSM state encoding, AXI response codes, default address width
//               and small helpers used by the arbiter and its RR sub-block.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_arb_pkg;

    localparam int AXI_ADDR_W_DEFAULT = 32;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Explicit 3-bit encoding keeps the state register width fixed
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4,
        ST_DONE  = 3'd5
    } arb_state_e;

    // Circular index used by the round-robin search
    function automatic int rr_wrap(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

    // AXI-Lite has no exclusive access, so anything other than OKAY
    // (EXOKAY included) is reported to the requester as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == AXI_RESP_EXOKAY) || (resp == AXI_RESP_SLVERR) ||
               (resp == AXI_RESP_DECERR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Searches the request vector
//               starting at ptr (the index after the last grant) and returns
//               the first active requester as a one-hot vector and an index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] w_cand;

    // Walk the requesters in circular order from ptr; first hit wins
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        w_cand      = '0;
        for (int off = 0; off < N_REQ; off++) begin
            w_cand = IDX_W'(rr_wrap(int'(ptr), off, N_REQ));
            if (!grant_valid && req[w_cand]) begin
                grant_valid   = 1'b1;
                grant[w_cand] = 1'b1;
                grant_idx     = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_lite_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_arbiter
// Description : Shares one AXI-Lite master port between N_REQ simple
//               request/done clients. Round-robin grant, one outstanding
//               transaction, single-cycle done pulse with read data / error.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_arbiter
    import axi_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = AXI_ADDR_W_DEFAULT
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    // requester side
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*32-1:0]     req_wdata,
    input  logic [N_REQ*4-1:0]      req_wstrb,
    output logic [N_REQ-1:0]        req_done,
    output logic [31:0]             req_rdata,
    output logic                    req_err,
    // AW channel
    output logic [ADDR_W-1:0]       m_axi_awaddr,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    // W channel
    output logic [31:0]             m_axi_wdata,
    output logic [3:0]              m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    // B channel
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    // AR channel
    output logic [ADDR_W-1:0]       m_axi_araddr,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    // R channel
    input  logic [31:0]             m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N_REQ - 1);

    arb_state_e         r_state;
    logic               r_started;
    logic [IDX_W-1:0]   r_ptr;
    logic [N_REQ-1:0]   r_grant_oh;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wstrb;
    logic               r_awvalid;
    logic               r_wvalid;
    logic [31:0]        r_rdata;
    logic               r_err;

    logic [N_REQ-1:0]   w_grant_oh;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_grant_valid;
    logic [IDX_W-1:0]   w_next_ptr;
    logic               w_aw_done;
    logic               w_w_done;

    logic [ADDR_W-1:0]  w_addr_arr  [N_REQ];
    logic [31:0]        w_wdata_arr [N_REQ];
    logic [3:0]         w_wstrb_arr [N_REQ];

    // Unpack the flat requester buses so the grant index can select a slot
    generate
        for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
            assign w_addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
            assign w_wdata_arr[g] = req_wdata[g*32 +: 32];
            assign w_wstrb_arr[g] = req_wstrb[g*4 +: 4];
        end
    endgenerate

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req         (req_valid),
        .ptr         (r_ptr),
        .grant       (w_grant_oh),
        .grant_idx   (w_grant_idx),
        .grant_valid (w_grant_valid)
    );

    assign w_next_ptr = (w_grant_idx == C_LAST_IDX) ? '0 : w_grant_idx + 1'b1;

    // A write channel counts as finished if its valid is already low or
    // it handshakes this cycle; this covers either order or both together.
    assign w_aw_done = ~r_awvalid | m_axi_awready;
    assign w_w_done  = ~r_wvalid  | m_axi_wready;

    // Main transaction FSM; first cycle after reset release never grants
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= ST_IDLE;
            r_started  <= 1'b0;
            r_ptr      <= '0;
            r_grant_oh <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_started <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (r_started && w_grant_valid) begin
                        r_grant_oh <= w_grant_oh;
                        r_ptr      <= w_next_ptr;
                        r_we       <= req_we[w_grant_idx];
                        r_addr     <= w_addr_arr[w_grant_idx];
                        r_wdata    <= w_wdata_arr[w_grant_idx];
                        r_wstrb    <= w_wstrb_arr[w_grant_idx];
                        r_rdata    <= '0;
                        r_err      <= 1'b0;
                        if (req_we[w_grant_idx]) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= ST_WRITE;
                        end else begin
                            r_state   <= ST_RADDR;
                        end
                    end
                end
                ST_WRITE: begin
                    if (m_axi_awready) begin
                        r_awvalid <= 1'b0;
                    end
                    if (m_axi_wready) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_state <= ST_WRESP;
                    end
                end
                ST_WRESP: begin
                    if (m_axi_bvalid) begin
                        r_err   <= resp_is_err(m_axi_bresp);
                        r_state <= ST_DONE;
                    end
                end
                ST_RADDR: begin
                    if (m_axi_arready) begin
                        r_state <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (m_axi_rvalid) begin
                        r_rdata <= m_axi_rdata;
                        r_err   <= resp_is_err(m_axi_rresp);
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // AXI side: address/data come straight from the latched request
    assign m_axi_awaddr  = r_addr;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = (r_state == ST_WRESP);
    assign m_axi_araddr  = r_addr;
    assign m_axi_arvalid = (r_state == ST_RADDR);
    assign m_axi_rready  = (r_state == ST_RDATA);

    // Requester side: results are only visible during the DONE cycle
    assign req_done  = (r_state == ST_DONE) ? r_grant_oh : '0;
    assign req_rdata = ((r_state == ST_DONE) && !r_we) ? r_rdata : '0;
    assign req_err   = (r_state == ST_DONE) && r_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_arbiter
// Description : Self-checking bench for axi_lite_arbiter (N_REQ=2). Directed
//               vector table plus hand-written reset / round-robin sequences,
//               against a configurable-latency AXI-Lite slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_arbiter;

    logic        aclk;
    logic        aresetn;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic [1:0]  req_done;
    logic [31:0] req_rdata;
    logic        req_err;
    logic [31:0] m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    int tests = 0;
    int fails = 0;

    axi_lite_arbiter #(.N_REQ(2), .ADDR_W(32)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_wstrb     (req_wstrb),
        .req_done      (req_done),
        .req_rdata     (req_rdata),
        .req_err       (req_err),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- slave model (acts on falling edges) ----------------
    int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0;
    logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
    logic [31:0] s_rdata = 32'h0;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, ncyc;
    int          aw_hs_cyc, w_hs_cyc, b_hs_n;
    bit          aw_got, w_got;
    logic        p_awvalid, p_wvalid, p_bready, p_arvalid, p_rready;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;

    // Ready/valid values set here are what the DUT samples at the next
    // rising edge; handshakes are detected from the previous falling-edge
    // snapshot, which equals what the DUT saw at the intervening edge.
    always @(negedge aclk) begin
        ncyc++;
        if (!aresetn) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
            m_axi_bvalid = 0; m_axi_bresp = 0;
            m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0;
            aw_got = 0; w_got = 0;
            p_awvalid = 0; p_wvalid = 0; p_bready = 0; p_arvalid = 0; p_rready = 0;
        end else begin
            if (m_axi_rvalid && p_rready) m_axi_rvalid = 0;
            if (m_axi_bvalid && p_bready) begin
                m_axi_bvalid = 0; b_hs_n++; aw_got = 0; w_got = 0; b_cnt = 0;
            end
            if (p_awvalid && m_axi_awready) begin
                aw_got = 1; aw_hs_cyc = ncyc; cap_awaddr = m_axi_awaddr;
            end
            if (p_wvalid && m_axi_wready) begin
                w_got = 1; w_hs_cyc = ncyc; cap_wdata = m_axi_wdata; cap_wstrb = m_axi_wstrb;
            end
            if (p_arvalid && m_axi_arready) begin
                cap_araddr = m_axi_araddr;
                m_axi_rvalid = 1; m_axi_rdata = s_rdata; m_axi_rresp = s_rresp;
            end
            if (p_awvalid && !m_axi_awready && !m_axi_awvalid) begin
                fails++; $display("FAIL awvalid_hold: got 0 expected 1");
            end
            if (p_wvalid && !m_axi_wready && !m_axi_wvalid) begin
                fails++; $display("FAIL wvalid_hold: got 0 expected 1");
            end
            if (p_arvalid && !m_axi_arready && !m_axi_arvalid) begin
                fails++; $display("FAIL arvalid_hold: got 0 expected 1");
            end
            m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_delay);
            aw_cnt = m_axi_awvalid ? aw_cnt + 1 : 0;
            m_axi_wready = m_axi_wvalid && (w_cnt >= w_delay);
            w_cnt = m_axi_wvalid ? w_cnt + 1 : 0;
            m_axi_arready = m_axi_arvalid && (ar_cnt >= ar_delay);
            ar_cnt = m_axi_arvalid ? ar_cnt + 1 : 0;
            if (aw_got && w_got && !m_axi_bvalid) begin
                if (b_cnt >= b_delay) begin
                    m_axi_bvalid = 1; m_axi_bresp = s_bresp;
                end else begin
                    b_cnt++;
                end
            end
            p_awvalid = m_axi_awvalid; p_wvalid = m_axi_wvalid; p_bready = m_axi_bready;
            p_arvalid = m_axi_arvalid; p_rready = m_axi_rready;
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        int          idx;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_d;
        int          w_d;
        int          ar_d;
        logic [1:0]  resp;
        logic [31:0] sdata;
        bit          drop;
        int          exp_lat;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs [8];

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, {57'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
              m_axi_arvalid, m_axi_rready, req_done}, 64'd0);
        check({tag, "_data"}, {63'd0, |{req_err, req_rdata, m_axi_awaddr, m_axi_araddr,
              m_axi_wdata, m_axi_wstrb}}, 64'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int          lat;
        int          b0;
        logic [1:0]  exp_oh;
        s_rdata = v.sdata; s_rresp = v.resp; s_bresp = v.resp;
        aw_delay = v.aw_d; w_delay = v.w_d; ar_delay = v.ar_d; b_delay = 0;
        b0 = b_hs_n;
        exp_oh = '0;
        exp_oh[v.idx] = 1'b1;
        @(negedge aclk);
        req_addr[v.idx*32 +: 32]  = v.addr;
        req_wdata[v.idx*32 +: 32] = v.wdata;
        req_wstrb[v.idx*4 +: 4]   = v.wstrb;
        req_we[v.idx]             = v.we;
        req_valid[v.idx]          = 1'b1;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge aclk);
            if (k == 1) begin
                // grant already taken: disturb the requester's inputs
                req_addr[v.idx*32 +: 32]  = 32'hFFFF_FFFF;
                req_wdata[v.idx*32 +: 32] = ~v.wdata;
                req_wstrb[v.idx*4 +: 4]   = ~v.wstrb;
                req_we[v.idx]             = ~v.we;
                if (v.drop) req_valid[v.idx] = 1'b0;
            end
            if (req_done != 2'b00) begin
                lat = k;
                break;
            end
        end
        check("latency", 64'(lat), 64'(v.exp_lat));
        check("done_onehot", {62'd0, req_done}, {62'd0, exp_oh});
        check("rdata", {32'd0, req_rdata}, {32'd0, v.exp_rdata});
        check("err", {63'd0, req_err}, {63'd0, v.exp_err});
        #1;
        if (v.we) begin
            check("awaddr", {32'd0, cap_awaddr}, {32'd0, v.addr});
            check("wdata_wstrb", {28'd0, cap_wdata, cap_wstrb}, {28'd0, v.wdata, v.wstrb});
            check("b_handshakes", 64'(b_hs_n - b0), 64'd1);
            if (v.aw_d > v.w_d) check("w_before_aw", {63'd0, w_hs_cyc < aw_hs_cyc}, 64'd1);
        end else begin
            check("araddr", {32'd0, cap_araddr}, {32'd0, v.addr});
        end
        req_valid[v.idx] = 1'b0;
        @(negedge aclk);
        check("done_width", {62'd0, req_done}, 64'd0);
    endtask

    initial begin
        int         nd;
        int         last;
        bit         found;
        logic [1:0] exp_oh;

        //            idx we addr           wdata          wstrb  aw w ar resp   sdata         drop lat exp_rdata     err
        vecs[0] = '{0, 0, 32'h4000_0010, 32'h0,         4'h0,   0, 0, 0, 2'b00, 32'hDEAD_BEEF, 0, 3, 32'hDEAD_BEEF, 0};
        vecs[1] = '{1, 1, 32'h4000_0004, 32'h1234_5678, 4'b0011, 3, 0, 0, 2'b00, 32'h0,         0, 6, 32'h0,         0};
        vecs[2] = '{0, 1, 32'h4000_0100, 32'hA5A5_0F0F, 4'b1111, 0, 0, 0, 2'b10, 32'h5555_5555, 0, 3, 32'h0,         1};
        vecs[3] = '{1, 0, 32'h4000_0020, 32'h0,         4'h0,   0, 0, 0, 2'b10, 32'hCAFE_0001, 0, 3, 32'hCAFE_0001, 1};
        vecs[4] = '{0, 0, 32'h4000_0024, 32'h0,         4'h0,   0, 0, 0, 2'b00, 32'h0000_0042, 1, 3, 32'h0000_0042, 0};
        vecs[5] = '{1, 1, 32'h4000_0008, 32'h0BAD_F00D, 4'b1100, 0, 2, 0, 2'b11, 32'h0,         1, 5, 32'h0,         1};
        vecs[6] = '{0, 0, 32'h4000_0030, 32'h0,         4'h0,   0, 0, 2, 2'b01, 32'h1111_2222, 0, 5, 32'h1111_2222, 1};
        vecs[7] = '{1, 1, 32'h4000_0040, 32'hFFFF_0000, 4'b0101, 1, 1, 0, 2'b00, 32'h0,         0, 4, 32'h0,         0};

        aresetn = 1'b0;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        b_hs_n = 0; ncyc = 0; aw_hs_cyc = 0; w_hs_cyc = 0;
        cap_awaddr = 0; cap_wdata = 0; cap_wstrb = 0; cap_araddr = 0;

        // ---- reset state, then no grant on the first edge after release ----
        s_rdata = 32'h0BEE_F001;
        req_addr[31:0] = 32'h4000_0000;
        req_valid = 2'b01;
        repeat (3) @(negedge aclk);
        check_reset_outputs("reset");
        aresetn = 1'b1;
        @(negedge aclk);
        check("no_grant_first_edge", {63'd0, m_axi_arvalid}, 64'd0);
        @(negedge aclk);
        check("grant_second_edge", {31'd0, m_axi_arvalid, m_axi_araddr}, {31'd0, 1'b1, 32'h4000_0000});
        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge aclk);
            if (req_done != 2'b00) begin
                found = 1;
                break;
            end
        end
        check("first_done", {62'd0, req_done}, 64'd1);
        check("first_rdata", {32'd0, req_rdata}, {32'd0, 32'h0BEE_F001});
        req_valid = '0;
        @(negedge aclk);

        // ---- table ----
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // ---- reset while in WRESP with bvalid pending ----
        aw_delay = 0; w_delay = 0; ar_delay = 0; b_delay = 1; s_bresp = 2'b00;
        @(negedge aclk);
        req_addr[31:0] = 32'h4000_0050; req_wdata[31:0] = 32'h7777_8888;
        req_wstrb[3:0] = 4'hF; req_we = 2'b01; req_valid = 2'b01;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge aclk);
            #2;
            if (m_axi_bvalid && m_axi_bready) begin
                found = 1;
                break;
            end
        end
        check("wresp_bvalid_pending", {63'd0, found}, 64'd1);
        aresetn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        req_valid = '0; b_delay = 0;
        repeat (2) @(negedge aclk);

        // ---- both requesters continuously: 0,1,0,1 with one IDLE between ----
        req_we = 2'b00;
        req_addr = {32'h4000_0064, 32'h4000_0060};
        s_rresp = 2'b00; s_rdata = 32'h0000_ABCD;
        req_valid = 2'b11;
        aresetn = 1'b1;
        nd = 0; last = 0;
        for (int k = 1; k <= 60 && nd < 4; k++) begin
            @(negedge aclk);
            if (req_done != 2'b00) begin
                exp_oh = (nd % 2 == 0) ? 2'b01 : 2'b10;
                check("rr_order", {62'd0, req_done}, {62'd0, exp_oh});
                check("rr_spacing", 64'(k - last), 64'd4);
                last = k;
                nd++;
            end
        end
        if (nd < 4) check("rr_done_count", 64'(nd), 64'd4);
        req_valid = '0;
        repeat (3) @(negedge aclk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
